// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch sequencer.
// Issues one-cycle read requests to instruction memory at pc, waits for the
// response (reissuing on timeout), holds the instruction for the control unit
// until it is acknowledged, then advances pc sequentially or to a redirect.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | post-reset bubble, moves straight to S_FETCH
// S_FETCH | imem_req pulse at imem_addr=pc, timeout counter cleared
// S_WAIT  | waiting for imem_rvalid, counting toward the reissue point
// S_HOLD  | ins valid, waiting for ins_ack to advance pc
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [7:0]  TIMEOUT  = 8'd16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        psel,
  input  logic [31:0] alu_data,
  input  logic        ins_ack,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ins,
  output logic        ins_vld,
  output logic [31:0] pc,
  output logic [31:0] pc_four,
  output logic        misalign
);

  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [7:0]  CNT_LAST = TIMEOUT - 8'd1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_WAIT  = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [7:0]  cnt;
  logic        clr_cnt;
  logic        inc_cnt;
  logic        load_ins;
  logic        load_pc;
  logic [31:0] pc_target;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and per-state control strobes
  always_comb begin
    state_next = state;
    imem_req   = 1'b0;
    ins_vld    = 1'b0;
    clr_cnt    = 1'b0;
    inc_cnt    = 1'b0;
    load_ins   = 1'b0;
    load_pc    = 1'b0;
    case (state)
      S_IDLE: begin
        state_next = S_FETCH;
      end
      S_FETCH: begin
        imem_req   = 1'b1;
        clr_cnt    = 1'b1;
        state_next = S_WAIT;
      end
      S_WAIT: begin
        // a response arriving on the last count wins over the reissue
        if (imem_rvalid) begin
          load_ins   = 1'b1;
          state_next = S_HOLD;
        end else if (cnt == CNT_LAST) begin
          state_next = S_FETCH;
        end else begin
          inc_cnt = 1'b1;
        end
      end
      S_HOLD: begin
        ins_vld = 1'b1;
        if (ins_ack) begin
          load_pc    = 1'b1;
          state_next = S_FETCH;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Response timeout counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= 8'd0;
    end else if (clr_cnt) begin
      cnt <= 8'd0;
    end else if (inc_cnt) begin
      cnt <= cnt + 8'd1;
    end
  end

  assign pc_four   = pc + 32'd4;
  assign pc_target = psel ? {alu_data[31:2], 2'b00} : pc_four;
  assign imem_addr = pc;

  // Instruction holding register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ins <= NOP;
    end else if (load_ins) begin
      ins <= imem_rdata;
    end
  end

  // pc update and misalign pulse, both taken on the acknowledging edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc       <= RESET_PC;
      misalign <= 1'b0;
    end else begin
      misalign <= load_pc & psel & (alu_data[1:0] != 2'b00);
      if (load_pc) begin
        pc <= pc_target;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed table-driven bench for fetch_unit.
module tb_fetch_unit;

  logic        clk;
  logic        reset_n;
  logic        psel;
  logic [31:0] alu_data;
  logic        ins_ack;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] ins;
  logic        ins_vld;
  logic [31:0] pc;
  logic [31:0] pc_four;
  logic        misalign;

  int n_cmp;
  int n_fail;

  fetch_unit #(
    .RESET_PC(32'h0000_0000),
    .TIMEOUT (8'd16)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .psel       (psel),
    .alu_data   (alu_data),
    .ins_ack    (ins_ack),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .ins        (ins),
    .ins_vld    (ins_vld),
    .pc         (pc),
    .pc_four    (pc_four),
    .misalign   (misalign)
  );

  // Free-running clock, 10 time-unit period
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        psel;
    logic [31:0] alu_data;
    logic [31:0] rdata;
    logic [31:0] cur_pc;
    logic [31:0] next_pc;
    logic        mis;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Main stimulus
  initial begin
    int n;
    n_cmp       = 0;
    n_fail      = 0;
    reset_n     = 1'b0;
    psel        = 1'b0;
    alu_data    = 32'h0;
    ins_ack     = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;

    //            psel  alu_data       rdata          cur_pc         next_pc        mis
    vecs[0] = '{1'b0, 32'h0000_0000, 32'h0050_0093, 32'h0000_0000, 32'h0000_0004, 1'b0};
    vecs[1] = '{1'b0, 32'h1234_5677, 32'h0010_0113, 32'h0000_0004, 32'h0000_0008, 1'b0};
    vecs[2] = '{1'b0, 32'h0000_0000, 32'h0020_0193, 32'h0000_0008, 32'h0000_000C, 1'b0};
    vecs[3] = '{1'b1, 32'h0000_0102, 32'h0000_006F, 32'h0000_000C, 32'h0000_0100, 1'b1};
    vecs[4] = '{1'b1, 32'hFFFF_FFFC, 32'h0040_0067, 32'h0000_0100, 32'hFFFF_FFFC, 1'b0};
    vecs[5] = '{1'b0, 32'h0000_0003, 32'h0000_0013, 32'hFFFF_FFFC, 32'h0000_0000, 1'b0};
    vecs[6] = '{1'b1, 32'h0000_2001, 32'hCAFE_0001, 32'h0000_0000, 32'h0000_2000, 1'b1};
    vecs[7] = '{1'b1, 32'h0000_0803, 32'hCAFE_0002, 32'h0000_2000, 32'h0000_0800, 1'b1};
    vecs[8] = '{1'b0, 32'h0000_0000, 32'hCAFE_0003, 32'h0000_0800, 32'h0000_0804, 1'b0};

    // Reset values
    repeat (3) @(negedge clk);
    #1;
    check("rst_ins", ins, 32'h0000_0013);
    check("rst_ins_vld", {31'b0, ins_vld}, 32'd0);
    check("rst_imem_req", {31'b0, imem_req}, 32'd0);
    check("rst_misalign", {31'b0, misalign}, 32'd0);
    check("rst_pc", pc, 32'h0);
    check("rst_pc_four", pc_four, 32'h4);

    // Release: IDLE for one cycle, then the first request
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("idle_no_req", {31'b0, imem_req}, 32'd0);
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      check($sformatf("v%0d_req", i), {31'b0, imem_req}, 32'd1);
      check($sformatf("v%0d_addr", i), imem_addr, vecs[i].cur_pc);
      check($sformatf("v%0d_req_novld", i), {31'b0, ins_vld}, 32'd0);
      @(negedge clk);
      check($sformatf("v%0d_wait_mis", i), {31'b0, misalign}, 32'd0);
      imem_rvalid = 1'b1;
      imem_rdata  = vecs[i].rdata;
      @(negedge clk);
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;
      check($sformatf("v%0d_vld", i), {31'b0, ins_vld}, 32'd1);
      check($sformatf("v%0d_hold_noreq", i), {31'b0, imem_req}, 32'd0);
      check($sformatf("v%0d_ins", i), ins, vecs[i].rdata);
      check($sformatf("v%0d_pc", i), pc, vecs[i].cur_pc);
      check($sformatf("v%0d_pc_four", i), pc_four, vecs[i].cur_pc + 32'd4);
      ins_ack  = 1'b1;
      psel     = vecs[i].psel;
      alu_data = vecs[i].alu_data;
      @(negedge clk);
      ins_ack  = 1'b0;
      psel     = 1'b0;
      alu_data = 32'h0;
      check($sformatf("v%0d_mis", i), {31'b0, misalign}, {31'b0, vecs[i].mis});
      check($sformatf("v%0d_next_pc", i), pc, vecs[i].next_pc);
    end

    // Ack and rvalid outside their states are ignored (now in FETCH at 0x804)
    ins_ack     = 1'b1;
    psel        = 1'b1;
    alu_data    = 32'h0000_0040;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h1111_1111;
    @(negedge clk);
    ins_ack     = 1'b0;
    psel        = 1'b0;
    alu_data    = 32'h0;
    imem_rvalid = 1'b0;
    check("stray_fetch_pc", pc, 32'h0000_0804);
    check("stray_fetch_ins", ins, 32'hCAFE_0003);
    check("stray_fetch_novld", {31'b0, ins_vld}, 32'd0);
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hAAAA_0001;
    @(negedge clk);
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    check("hold_ins", ins, 32'hAAAA_0001);
    repeat (2) @(negedge clk);
    imem_rvalid = 1'b0;
    check("stray_hold_ins", ins, 32'hAAAA_0001);
    check("stray_hold_vld", {31'b0, ins_vld}, 32'd1);
    check("stray_hold_noreq", {31'b0, imem_req}, 32'd0);
    check("stray_hold_pc", pc, 32'h0000_0804);
    ins_ack = 1'b1;
    @(negedge clk);
    ins_ack = 1'b0;

    // Timeout reissue: second request 17 cycles after the first, same address
    check("to_req1", {31'b0, imem_req}, 32'd1);
    check("to_addr1", imem_addr, 32'h0000_0808);
    n = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (imem_req) begin
        n = k;
        break;
      end
    end
    check("to_gap", n, 32'd17);
    check("to_addr2", imem_addr, 32'h0000_0808);
    check("to_novld", {31'b0, ins_vld}, 32'd0);

    // Response on the 16th WAIT cycle beats the reissue
    repeat (16) @(negedge clk);
    check("to_last_noreq", {31'b0, imem_req}, 32'd0);
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h0BAD_F00D;
    @(negedge clk);
    imem_rvalid = 1'b0;
    check("to_last_vld", {31'b0, ins_vld}, 32'd1);
    check("to_last_noreq2", {31'b0, imem_req}, 32'd0);
    check("to_last_ins", ins, 32'h0BAD_F00D);
    repeat (3) @(negedge clk);
    check("to_still_hold", {31'b0, ins_vld}, 32'd1);

    // Reset asserted in HOLD without ack
    #2;
    reset_n = 1'b0;
    #1;
    check("hold_rst_ins", ins, 32'h0000_0013);
    check("hold_rst_vld", {31'b0, ins_vld}, 32'd0);
    check("hold_rst_pc", pc, 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("hold_rst_idle", {31'b0, imem_req}, 32'd0);
    @(negedge clk);
    check("hold_rst_req", {31'b0, imem_req}, 32'd1);
    check("hold_rst_addr", imem_addr, 32'h0000_0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC value loaded on reset.
REQ-002 SHALL have parameter TIMEOUT, default 8'd16, meaning WAIT cycles before the memory request is reissued.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 reset_n  in  1  reset, asynchronous and active-low.
REQ-005 psel  in  1  PC select from control unit; 1 = take the redirect target.
REQ-006 alu_data  in  32  redirect target, valid while ins_vld=1.
REQ-007 ins_ack  in  1  downstream has consumed the current instruction.
REQ-008 imem_req  out  1  instruction memory read request, one-cycle pulse.
REQ-009 imem_addr  out  32  read address, equal to pc.
REQ-010 imem_rvalid  in  1  read data valid.
REQ-011 imem_rdata  in  32  read data.
REQ-012 ins  out  32  held instruction to the control unit.
REQ-013 ins_vld  out  1  ins is valid.
REQ-014 pc  out  32  address of the held or pending instruction.
REQ-015 pc_four  out  32  pc+4, used for JAL/JALR writeback.
REQ-016 misalign  out  1  one-cycle pulse: the redirect target had bits [1:0] != 0.

Function
REQ-017 SHALL implement the FSM states IDLE, FETCH, WAIT and HOLD, with all transitions on the clk rising edge.
REQ-018 IDLE: SHALL transition unconditionally to FETCH.
REQ-019 FETCH: SHALL drive imem_req=1 and imem_addr=pc for exactly one cycle, clear the timeout counter, then go to WAIT.
REQ-020 WAIT: on imem_rvalid=1, SHALL register ins<=imem_rdata and go to HOLD; otherwise it SHALL increment the 8-bit timeout counter.
REQ-021 WAIT: when the counter reaches TIMEOUT-1 with imem_rvalid=0, SHALL return to FETCH and reissue the request at the same pc.
REQ-022 HOLD: SHALL assert ins_vld=1 and keep ins, pc and pc_four stable until ins_ack=1.
REQ-023 HOLD with ins_ack=1: SHALL load pc<={alu_data[31:2],2'b00} if psel=1, else pc<=pc+4, and go to FETCH.
REQ-024 Latency: SHALL move from ack in HOLD to FETCH (1 cycle), then WAIT, then HOLD on the rvalid cycle, giving a minimum of 3 cycles per instruction when rvalid returns the cycle after imem_req.
REQ-025 SHALL pulse misalign for one cycle, coincident with the pc update, when psel=1, ins_ack=1 and alu_data[1:0]!=0.
REQ-026 pc+4 SHALL wrap modulo 2^32; 32'hFFFF_FFFC SHALL advance to 32'h0000_0000.
REQ-027 pc_four SHALL equal pc+4 combinationally, with the same wrap as REQ-026.
REQ-028 imem_rvalid outside WAIT SHALL be ignored, with no change to ins or state.
REQ-029 imem_rvalid on the timeout cycle SHALL take priority: capture the data and go to HOLD, with no reissue.
REQ-030 ins_ack outside HOLD SHALL be ignored.
REQ-031 psel and alu_data SHALL be sampled only on the HOLD cycle in which ins_ack=1.
REQ-032 ins_vld and imem_req SHALL never both be 1 in the same cycle.

Reset
REQ-033 While reset_n=0, SHALL force asynchronously: state=IDLE, pc=RESET_PC, ins=32'h0000_0013 (NOP), ins_vld=0, imem_req=0, misalign=0, counter=0.
REQ-034 When reset asserts mid-operation (WAIT or HOLD), SHALL discard any pending response; after deassertion the first imem_req SHALL occur 1 cycle later (IDLE then FETCH) at RESET_PC.

Verification
REQ-035 Reset release, memory returns 32'h0050_0093 one cycle after req -> imem_req at cycle 1 with addr 0; ins_vld=1 at cycle 3 with ins=32'h0050_0093 and pc_four=4.
REQ-036 Sequential: ack with psel=0 at pc=8 -> next imem_addr=12; at pc=32'hFFFF_FFFC -> next imem_addr=0.
REQ-037 Redirect: ack with psel=1, alu_data=32'h0000_0102 -> next imem_addr=32'h0000_0100 and misalign=1 for one cycle.
REQ-038 Timeout with TIMEOUT=16 and no rvalid -> second imem_req 17 cycles after the first, at the same address; rvalid on cycle 16 of WAIT -> no reissue, ins captured.
REQ-039 Reset asserted in HOLD with ins_ack=0 -> ins=32'h0000_0013 and ins_vld=0 immediately; after release, imem_addr=RESET_PC.
REQ-040 Stray rvalid during HOLD with data 32'hDEAD_BEEF -> ins unchanged, no state change.
